// File: rtl/mult_round_pipe.sv
// Signed multiply-and-round pipeline with per-sample rounding mode,
// optional output saturation and valid/ready flow control.
// Four stages: operand capture, product, rounded sum + tie detect, LSB fix + clamp.
module mult_round_pipe #(
  parameter int unsigned A_W      = 24,
  parameter int unsigned B_W      = 16,
  parameter int unsigned FRAC_W   = 16,
  parameter int unsigned OUT_W    = 24,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  z,
  output logic                     sat
);

  localparam int unsigned PW = A_W + B_W;         // exact product width
  localparam int unsigned SW = PW + 1;            // sum width, cannot overflow
  localparam int unsigned RW = PW - FRAC_W + 1;   // rounded result width

  localparam logic [1:0] MODE_TRUNC = 2'd0;
  localparam logic [1:0] MODE_HALF  = 2'd1;
  localparam logic [1:0] MODE_EVEN  = 2'd2;
  localparam logic [1:0] MODE_ODD   = 2'd3;

  // Half-LSB minus one; the extra +1 for half-up / convergent-even rides on carry-in
  localparam logic [SW-1:0] HALF_M1 =
    {{(SW-FRAC_W+1){1'b0}}, {(FRAC_W-1){1'b1}}};

  localparam logic signed [RW-1:0] Z_MAX =
    {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] Z_MIN =
    {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic                     adv;

  logic                     s1_v;
  logic signed [A_W-1:0]    s1_a;
  logic signed [B_W-1:0]    s1_b;
  logic [1:0]               s1_mode;

  logic                     s2_v;
  logic signed [PW-1:0]     s2_p;
  logic [1:0]               s2_mode;

  logic                     s3_v;
  logic [RW-1:0]            s3_r;
  logic                     s3_tie;
  logic                     s3_lsb;

  logic [SW-1:0]            rnd_c;
  logic                     cin_c;
  logic [SW-1:0]            sum_c;
  logic                     tie_c;

  logic signed [RW-1:0]     r_c;
  logic signed [OUT_W-1:0]  z_c;
  logic                     sat_c;

  // Whole pipeline moves together whenever the output slot is free or draining
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // S1: capture operands and mode with the sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= MODE_TRUNC;
    end else if (adv) begin
      s1_v    <= in_valid;
      s1_a    <= a;
      s1_b    <= b;
      s1_mode <= mode;
    end
  end

  // S2: exact signed product
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_p    <= '0;
      s2_mode <= MODE_TRUNC;
    end else if (adv) begin
      s2_v    <= s1_v;
      s2_p    <= PW'(s1_a) * PW'(s1_b);
      s2_mode <= s1_mode;
    end
  end

  // Rounding constant (C operand) plus carry-in, and tie pattern on the discarded bits
  always_comb begin
    rnd_c = '0;
    cin_c = 1'b0;
    tie_c = 1'b0;
    case (s2_mode)
      MODE_HALF, MODE_EVEN: begin
        rnd_c = HALF_M1;
        cin_c = 1'b1;
      end
      MODE_ODD: rnd_c = HALF_M1;
      default: ;
    endcase
    sum_c = SW'(s2_p) + rnd_c + SW'(cin_c);
    if (s2_mode == MODE_EVEN) begin
      tie_c = (sum_c[FRAC_W-1:0] == '0);
    end else if (s2_mode == MODE_ODD) begin
      tie_c = &sum_c[FRAC_W-1:0];
    end
  end

  // S3: shifted sum and tie flag; forced LSB value is mode bit 0 (even -> 0, odd -> 1)
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v   <= 1'b0;
      s3_r   <= '0;
      s3_tie <= 1'b0;
      s3_lsb <= 1'b0;
    end else if (adv) begin
      s3_v   <= s2_v;
      s3_r   <= sum_c[PW:FRAC_W];
      s3_tie <= tie_c;
      s3_lsb <= s2_mode[0];
    end
  end

  // Convergent LSB fix, then clamp or wrap to the output width
  always_comb begin
    r_c = s3_r;
    if (s3_tie) begin
      r_c[0] = s3_lsb;
    end
    z_c   = r_c[OUT_W-1:0];
    sat_c = 1'b0;
    if (SATURATE) begin
      if (r_c > Z_MAX) begin
        z_c   = Z_MAX[OUT_W-1:0];
        sat_c = 1'b1;
      end else if (r_c < Z_MIN) begin
        z_c   = Z_MIN[OUT_W-1:0];
        sat_c = 1'b1;
      end
    end
  end

  // S4: output registers, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      out_valid <= s3_v;
      z         <= z_c;
      sat       <= sat_c;
    end
  end

endmodule

// File: tb/tb_mult_round_pipe.sv
// Bench for mult_round_pipe: four configurations share one stimulus stream and
// are checked every cycle against an arithmetic rounding model and a latency queue.
`timescale 1ns/1ps
module tb_mult_round_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [23:0] a_in;
  logic [17:0] b_in;
  logic [1:0]  mode;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        sat0, sat1, sat2, sat3;
  logic [23:0] z0;
  logic [15:0] z1, z2;
  logic [11:0] z3;

  int n_total = 0;
  int n_bad   = 0;

  // cfg0 defaults, cfg1 OUT_W=16 clamp, cfg2 OUT_W=16 wrap, cfg3 18x18 FRAC 4 OUT 12
  mult_round_pipe d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a_in), .b(b_in[15:0]), .mode(mode),
    .out_valid(ov0), .out_ready(out_ready), .z(z0), .sat(sat0));

  mult_round_pipe #(.OUT_W(16)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a_in), .b(b_in[15:0]), .mode(mode),
    .out_valid(ov1), .out_ready(out_ready), .z(z1), .sat(sat1));

  mult_round_pipe #(.OUT_W(16), .SATURATE(1'b0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a_in), .b(b_in[15:0]), .mode(mode),
    .out_valid(ov2), .out_ready(out_ready), .z(z2), .sat(sat2));

  mult_round_pipe #(.A_W(18), .B_W(18), .FRAC_W(4), .OUT_W(12)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
    .a(a_in[17:0]), .b(b_in), .mode(mode),
    .out_valid(ov3), .out_ready(out_ready), .z(z3), .sat(sat3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    logic [63:0] x;
    m = (64'd1 << w) - 64'd1;
    x = v & m;
    if (x[w-1]) return longint'(x) - longint'(64'd1 << w);
    return longint'(x);
  endfunction

  // Rounding by arithmetic: floor quotient and remainder, then nearest with the mode's tie rule
  function automatic void model(input int cfg, input logic [23:0] ar, input logic [17:0] br,
                                input logic [1:0] md, output logic [63:0] zq, output logic sq);
    int aw, bw, fw, ow;
    bit sp;
    longint av, bv, p, q, rem, h, r, lo, hi;
    aw = 24; bw = 16; fw = 16; ow = 24; sp = 1'b1;
    case (cfg)
      1: ow = 16;
      2: begin ow = 16; sp = 1'b0; end
      3: begin aw = 18; bw = 18; fw = 4; ow = 12; end
      default: ;
    endcase
    av  = sext(64'(ar), aw);
    bv  = sext(64'(br), bw);
    p   = av * bv;
    h   = longint'(1) <<< (fw - 1);
    q   = p >>> fw;
    rem = p - (q <<< fw);
    case (md)
      2'd0: r = q;
      2'd1: r = (rem >= h) ? q + 1 : q;
      2'd2: r = (rem > h) ? q + 1 : ((rem == h) ? q + (q & 1) : q);
      default: r = (rem > h) ? q + 1 : ((rem == h) ? q + ((q & 1) ^ 1) : q);
    endcase
    lo = -(longint'(1) <<< (ow - 1));
    hi = -lo - 1;
    sq = 1'b0;
    if (sp && r > hi) begin
      r = hi; sq = 1'b1;
    end else if (sp && r < lo) begin
      r = lo; sq = 1'b1;
    end
    zq = 64'(r) & ((64'd1 << ow) - 64'd1);
  endfunction

  function automatic logic [63:0] dut_z(input int c);
    case (c)
      0: return 64'(z0);
      1: return 64'(z1);
      2: return 64'(z2);
      default: return 64'(z3);
    endcase
  endfunction

  function automatic logic dut_sat(input int c);
    case (c)
      0: return sat0;
      1: return sat1;
      2: return sat2;
      default: return sat3;
    endcase
  endfunction

  // Each accepted sample emerges after exactly four advancing edges
  typedef struct {
    logic [23:0] a;
    logic [17:0] b;
    logic [1:0]  m;
    int          tag;
  } item_t;

  item_t sbq[$];
  item_t it;
  int    adv_cnt   = 0;
  bit    exp_valid = 1'b0;
  bit    started   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      sbq.delete();
      exp_valid = 1'b0;
      started   = 1'b1;
    end else if (out_ready || !exp_valid) begin
      if (exp_valid) void'(sbq.pop_front());
      if (in_valid) begin
        it.a = a_in; it.b = b_in; it.m = mode; it.tag = adv_cnt;
        sbq.push_back(it);
      end
      adv_cnt++;
      exp_valid = (sbq.size() != 0) && (sbq[0].tag + 4 == adv_cnt);
    end
  end

  // Per-cycle comparison of all instances against the model
  logic [63:0] prev_z = '0;
  bit          hold_prev = 1'b0;

  always @(negedge clk) begin
    logic [63:0] ez;
    logic        es;
    if (started) begin
      chk("out_valid", 64'({ov3, ov2, ov1, ov0}), 64'({4{exp_valid}}));
      chk("in_ready", 64'({ir3, ir2, ir1, ir0}), 64'({4{out_ready | ~exp_valid}}));
      if (exp_valid && sbq.size() != 0) begin
        for (int c = 0; c < 4; c++) begin
          model(c, sbq[0].a, sbq[0].b, sbq[0].m, ez, es);
          chk($sformatf("z_cfg%0d", c), dut_z(c), ez);
          chk($sformatf("sat_cfg%0d", c), 64'(dut_sat(c)), 64'(es));
        end
      end
      if (hold_prev) chk("z_hold", 64'(z0), prev_z);
      hold_prev = ov0 && !out_ready && !rst;
      prev_z    = 64'(z0);
    end
  end

  logic [23:0] cap_z0;
  logic [15:0] cap_z1, cap_z2;
  logic        cap_s1, cap_s2;

  // Send one sample into an idle pipe and capture the first result; returns edges-1 latency index
  task automatic send_get(input logic [23:0] av, input logic [17:0] bv, input logic [1:0] md,
                          output int lat);
    in_valid = 1'b1; a_in = av; b_in = bv; mode = md;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov0) begin
        lat = i;
        break;
      end
    end
    cap_z0 = z0; cap_z1 = z1; cap_z2 = z2; cap_s1 = sat1; cap_s2 = sat2;
    @(posedge clk); #1;
  endtask

  localparam logic [23:0] TIE_A [4] = '{24'h000002, 24'h000006, 24'hFFFFFA, 24'h000003};
  localparam logic [23:0] TIE_Z [16] = '{
    24'h000000, 24'h000001, 24'h000000, 24'h000001,
    24'h000001, 24'h000002, 24'h000002, 24'h000001,
    24'hFFFFFE, 24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFF,
    24'h000000, 24'h000001, 24'h000001, 24'h000001};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] mz;
    logic        ms;
    int          lat, first, last, cnt;
    bit          acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; mode = 2'd0;

    // Pin the model to hand-computed values
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 4; m++) begin
        model(0, TIE_A[i], 18'h04000, 2'(m), mz, ms);
        chk($sformatf("pin_tie_a%0d_m%0d", i, m), mz, 64'(TIE_Z[i*4+m]));
      end
    end
    model(1, 24'h7FFFFF, 18'h07FFF, 2'd0, mz, ms);
    chk("pin_sat_pos", {mz[62:0], ms}, {63'h7FFF, 1'b1});
    model(1, 24'h800000, 18'h07FFF, 2'd0, mz, ms);
    chk("pin_sat_neg", {mz[62:0], ms}, {63'h8000, 1'b1});
    model(2, 24'h7FFFFF, 18'h07FFF, 2'd0, mz, ms);
    chk("pin_wrap", {mz[62:0], ms}, {63'hFF7F, 1'b0});

    // Reset state, in_ready high during reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_z", 64'(z0), 64'd0);
    chk("rst_sat", 64'(sat0), 64'd0);
    chk("rst_in_ready", 64'(ir0), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie / non-tie table, all modes
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 4; m++) begin
        send_get(TIE_A[i], 18'h04000, 2'(m), lat);
        chk($sformatf("tie_lat_a%0d_m%0d", i, m), 64'(lat), 64'd3);
        chk($sformatf("tie_z_a%0d_m%0d", i, m), 64'(cap_z0), 64'(TIE_Z[i*4+m]));
      end
    end

    // Saturation and wrap
    send_get(24'h7FFFFF, 18'h07FFF, 2'd0, lat);
    chk("sat_pos_z", 64'(cap_z1), 64'h7FFF);
    chk("sat_pos_flag", 64'(cap_s1), 64'd1);
    chk("wrap_z", 64'(cap_z2), 64'hFF7F);
    chk("wrap_flag", 64'(cap_s2), 64'd0);
    send_get(24'h800000, 18'h07FFF, 2'd0, lat);
    chk("sat_neg_z", 64'(cap_z1), 64'h8000);
    chk("sat_neg_flag", 64'(cap_s1), 64'd1);
    send_get(24'h000006, 18'h04000, 2'd2, lat);
    chk("nosat_z", 64'(cap_z1), 64'h0002);
    chk("nosat_flag", 64'(cap_s1), 64'd0);

    // Back-to-back stream of 8 with mode cycling
    first = -1; last = -1; cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1;
          a_in = 24'(i * 40503 - 100000);
          b_in = 18'h04000 + 18'(i * 77);
          mode = 2'(i);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          if (ov0) begin
            cnt++;
            if (first < 0) first = j;
            last = j;
          end
        end
      end
    join
    chk("b2b_first", 64'(first), 64'd4);
    chk("b2b_count", 64'(cnt), 64'd8);
    chk("b2b_run", 64'(last - first + 1), 64'd8);
    @(posedge clk); #1;

    // Backpressure: 5-cycle stall mid-stream with in_valid held
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          in_valid = 1'b1;
          a_in = 24'($urandom);
          b_in = 18'($urandom);
          mode = 2'($urandom);
          do begin
            @(negedge clk);
            acc = ir0;
            @(posedge clk); #1;
          end while (!acc);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    chk("bp_drained", 64'(sbq.size()), 64'd0);

    // Reset with three samples in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a_in = 24'(1000 + i);
      b_in = 18'h04000;
      mode = 2'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 64'(ov0), 64'd0);
    chk("midrst_z", 64'(z0), 64'd0);
    chk("midrst_sat", 64'(sat0), 64'd0);
    send_get(24'h000006, 18'h04000, 2'd1, lat);
    chk("midrst_lat", 64'(lat), 64'd3);
    chk("midrst_z_new", 64'(cap_z0), 64'h000002);

    // Random traffic across all four configurations
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a_in = 24'($urandom_range(0, 15)) - 24'd8;
        b_in = 18'h04000;
      end else begin
        a_in = 24'($urandom);
        b_in = 18'($urandom);
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
